// File: rtl/eth_rmii_rx.sv
// RMII receive front-end: PHY clock/reset generation, dibit sampling, preamble/SFD strip,
// byte assembly with one-byte hold, error and CRC-32 status. CRC logic built only with ETH_CRC_CHECK_EN.
module eth_rmii_rx (
    input  logic       clk,
    input  logic       reset,
    output logic       eth_clk,
    output logic       eth_resetn,
    input  logic [1:0] eth_rxd,
    input  logic       eth_crs_dv,
    input  logic       eth_rx_err,
    output logic [1:0] eth_txd,
    output logic       eth_tx_en,
    output logic [7:0] rx_data,
    output logic       rx_vld,
    output logic       rx_last,
    output logic       rx_err,
    output logic       rx_crc_ok
);

    typedef enum logic [1:0] {IDLE, SYNC, DATA} state_t;

    state_t      state_q, state_d;
    logic        ph_q, resetn_q;
    logic [1:0]  rxd_q;
    logic        crs_q, rxer_q;
    logic [1:0]  prev_q, prev_d;
    logic [7:0]  sr_q, sr_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [7:0]  hold_q, hold_d;
    logic        full_q, full_d;
    logic        err_q, err_d;
    logic        vld_q, vld_d;
    logic [7:0]  data_q, data_d;
    logic        last_q, last_d;
    logic        oerr_q, oerr_d;
    logic        ok_q, ok_d;

`ifdef ETH_CRC_CHECK_EN
    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

    logic [31:0] crc_q, crc_d;

    // Reflected CRC-32, two bits per dibit, bit 0 enters first.
    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [1:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 2; i++) begin
            if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB8_8320;
            else             r = r >> 1;
        end
        return r;
    endfunction
`endif

    assign eth_clk    = ph_q;
    assign eth_resetn = resetn_q;
    assign eth_txd    = 2'b00;
    assign eth_tx_en  = 1'b0;
    assign rx_data    = data_q;
    assign rx_vld     = vld_q;
    assign rx_last    = last_q;
    assign rx_err     = oerr_q;
    assign rx_crc_ok  = ok_q;

    // Inputs are captured while ph_q=0; the cycle with ph_q=1 processes that sample.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ph_q     <= 1'b0;
            resetn_q <= 1'b0;
            rxd_q    <= 2'b00;
            crs_q    <= 1'b0;
            rxer_q   <= 1'b0;
        end else begin
            ph_q     <= ~ph_q;
            resetn_q <= 1'b1;
            if (!ph_q) begin
                rxd_q  <= eth_rxd;
                crs_q  <= eth_crs_dv;
                rxer_q <= eth_rx_err;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (ph_q) begin
            case (state_q)
                IDLE: if (crs_q) state_d = SYNC;
                SYNC: begin
                    if (!crs_q)                                  state_d = IDLE;
                    else if (rxd_q == 2'b11 && prev_q == 2'b01)  state_d = DATA;
                end
                DATA: if (!crs_q) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        prev_d = prev_q;
        sr_d   = sr_q;
        cnt_d  = cnt_q;
        hold_d = hold_q;
        full_d = full_q;
        err_d  = err_q;
        vld_d  = 1'b0;
        data_d = 8'h00;
        last_d = 1'b0;
        oerr_d = 1'b0;
        ok_d   = 1'b0;
`ifdef ETH_CRC_CHECK_EN
        crc_d  = crc_q;
`endif
        if (ph_q) begin
            case (state_q)
                IDLE: begin
                    if (crs_q) begin
                        prev_d = 2'b00;
                        cnt_d  = 2'd0;
                        full_d = 1'b0;
                        err_d  = 1'b0;
`ifdef ETH_CRC_CHECK_EN
                        crc_d  = CRC_INIT;
`endif
                    end
                end
                SYNC: begin
                    prev_d = rxd_q;
                    if (rxer_q) err_d = 1'b1;
                end
                DATA: begin
                    if (crs_q) begin
                        sr_d  = {rxd_q, sr_q[7:2]};
                        cnt_d = cnt_q + 2'd1;
                        if (rxer_q) err_d = 1'b1;
`ifdef ETH_CRC_CHECK_EN
                        crc_d = crc_step(crc_q, rxd_q);
`endif
                        // A completed byte pushes the previously held one out.
                        if (cnt_q == 2'd3) begin
                            hold_d = sr_d;
                            full_d = 1'b1;
                            if (full_q) begin
                                vld_d  = 1'b1;
                                data_d = hold_q;
                            end
                        end
                    end else begin
                        if (full_q) begin
                            vld_d  = 1'b1;
                            data_d = hold_q;
                            last_d = 1'b1;
                            oerr_d = err_q | rxer_q | (cnt_q != 2'd0);
`ifdef ETH_CRC_CHECK_EN
                            ok_d   = (crc_q == CRC_RESIDUE) && (cnt_q == 2'd0);
`endif
                        end
                        full_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q <= 2'b00;
            sr_q   <= 8'h00;
            cnt_q  <= 2'd0;
            hold_q <= 8'h00;
            full_q <= 1'b0;
            err_q  <= 1'b0;
            vld_q  <= 1'b0;
            data_q <= 8'h00;
            last_q <= 1'b0;
            oerr_q <= 1'b0;
            ok_q   <= 1'b0;
        end else begin
            prev_q <= prev_d;
            sr_q   <= sr_d;
            cnt_q  <= cnt_d;
            hold_q <= hold_d;
            full_q <= full_d;
            err_q  <= err_d;
            vld_q  <= vld_d;
            data_q <= data_d;
            last_q <= last_d;
            oerr_q <= oerr_d;
            ok_q   <= ok_d;
        end
    end

`ifdef ETH_CRC_CHECK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) crc_q <= CRC_INIT;
        else       crc_q <= crc_d;
    end
`endif

endmodule

// File: tb/tb_eth_rmii_rx.sv
// Directed bench for eth_rmii_rx: reset behaviour, classic FCS frame, corrupted frame,
// short frames with error/truncation, and a carrier burst without SFD.
module tb_eth_rmii_rx;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       eth_clk, eth_resetn;
    logic [1:0] eth_rxd = 2'b00;
    logic       eth_crs_dv = 1'b0;
    logic       eth_rx_err = 1'b0;
    logic [1:0] eth_txd;
    logic       eth_tx_en;
    logic [7:0] rx_data;
    logic       rx_vld, rx_last, rx_err, rx_crc_ok;

    int checks = 0;
    int errors = 0;

`ifdef ETH_CRC_CHECK_EN
    localparam logic CRC_EN = 1'b1;
`else
    localparam logic CRC_EN = 1'b0;
`endif

    logic [7:0] classic [0:63] = '{
        8'h00, 8'h10, 8'hA4, 8'h7B, 8'hEA, 8'h80, 8'h00, 8'h12,
        8'h34, 8'h56, 8'h78, 8'h90, 8'h08, 8'h00, 8'h45, 8'h00,
        8'h00, 8'h2E, 8'hB3, 8'hFE, 8'h00, 8'h00, 8'h80, 8'h11,
        8'h05, 8'h40, 8'hC0, 8'hA8, 8'h00, 8'h2C, 8'hC0, 8'hA8,
        8'h00, 8'h04, 8'h04, 8'h00, 8'h04, 8'h00, 8'h00, 8'h1A,
        8'h2D, 8'hE8, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
        8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D,
        8'h0E, 8'h0F, 8'h10, 8'h11, 8'hE6, 8'hC5, 8'h3D, 8'hB2
    };
    logic [7:0] frm [0:63];

    logic [7:0] cap_data [0:511];
    logic       cap_last [0:511];
    logic       cap_err  [0:511];
    logic       cap_ok   [0:511];
    int         cap_n = 0;
    int         dbl_vld = 0;
    logic       prev_vld = 1'b0;

    eth_rmii_rx dut (
        .clk        (clk),
        .reset      (reset),
        .eth_clk    (eth_clk),
        .eth_resetn (eth_resetn),
        .eth_rxd    (eth_rxd),
        .eth_crs_dv (eth_crs_dv),
        .eth_rx_err (eth_rx_err),
        .eth_txd    (eth_txd),
        .eth_tx_en  (eth_tx_en),
        .rx_data    (rx_data),
        .rx_vld     (rx_vld),
        .rx_last    (rx_last),
        .rx_err     (rx_err),
        .rx_crc_ok  (rx_crc_ok)
    );

    always #5 clk = ~clk;

    // Output monitor: records every delivered byte and flags back-to-back strobes.
    always @(negedge clk) begin
        if (rx_vld && prev_vld) dbl_vld++;
        prev_vld = rx_vld;
        if (rx_vld && cap_n < 512) begin
            cap_data[cap_n] = rx_data;
            cap_last[cap_n] = rx_last;
            cap_err[cap_n]  = rx_err;
            cap_ok[cap_n]   = rx_crc_ok;
            cap_n++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Dibit is set just after a non-sampling edge and held for two clocks.
    task automatic sendDibit(input logic [1:0] d, input logic crs, input logic er);
        eth_rxd    = d;
        eth_crs_dv = crs;
        eth_rx_err = er;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic sendByte(input logic [7:0] b, input logic er);
        for (int k = 0; k < 4; k++) sendDibit(b[2*k +: 2], 1'b1, er);
    endtask

    task automatic applyStimulus(input int n, input int err_byte, input int extra);
        for (int i = 0; i < 3; i++) sendDibit(2'b00, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) sendByte(8'h55, 1'b0);
        sendByte(8'hD5, 1'b0);
        for (int i = 0; i < n; i++) sendByte(frm[i], (i == err_byte));
        for (int i = 0; i < extra; i++) sendDibit(2'b11, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) sendDibit(2'b00, 1'b0, 1'b0);
    endtask

    task automatic checkFrame(input string tag, input int base, input int n,
                              input logic exp_err, input logic exp_ok);
        int nlast;
        int idx;
        nlast = 0;
        checkOutput({tag, "_count"}, cap_n - base, n);
        for (int i = base; i < cap_n; i++) if (cap_last[i]) nlast++;
        for (int i = 0; i < n; i++)
            checkOutput($sformatf("%s_byte%0d", tag, i), {24'h0, cap_data[base + i]}, {24'h0, frm[i]});
        checkOutput({tag, "_nlast"}, nlast, 1);
        idx = base + n - 1;
        checkOutput({tag, "_last"},   {31'h0, cap_last[idx]}, 32'd1);
        checkOutput({tag, "_err"},    {31'h0, cap_err[idx]},  {31'h0, exp_err});
        checkOutput({tag, "_crc_ok"}, {31'h0, cap_ok[idx]},   {31'h0, exp_ok});
    endtask

    initial begin
        int base;
        for (int i = 0; i < 64; i++) frm[i] = classic[i];

        repeat (3) @(negedge clk);
        checkOutput("rst_rx_vld",     {31'h0, rx_vld},     32'd0);
        checkOutput("rst_rx_data",    {24'h0, rx_data},    32'd0);
        checkOutput("rst_rx_last",    {31'h0, rx_last},    32'd0);
        checkOutput("rst_rx_err",     {31'h0, rx_err},     32'd0);
        checkOutput("rst_rx_crc_ok",  {31'h0, rx_crc_ok},  32'd0);
        checkOutput("rst_eth_clk",    {31'h0, eth_clk},    32'd0);
        checkOutput("rst_eth_resetn", {31'h0, eth_resetn}, 32'd0);
        checkOutput("rst_eth_txd",    {30'h0, eth_txd},    32'd0);
        checkOutput("rst_eth_tx_en",  {31'h0, eth_tx_en},  32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        checkOutput("rel_eth_resetn", {31'h0, eth_resetn}, 32'd1);
        checkOutput("rel_eth_clk_hi", {31'h0, eth_clk},    32'd1);
        @(posedge clk); #1;
        checkOutput("rel_eth_clk_lo", {31'h0, eth_clk},    32'd0);

        $display("[TB] classic FCS frame");
        base = cap_n;
        applyStimulus(64, -1, 0);
        checkFrame("classic", base, 64, 1'b0, CRC_EN);

        $display("[TB] corrupted payload byte");
        frm[47] = 8'h04;
        base = cap_n;
        applyStimulus(64, -1, 0);
        checkFrame("corrupt", base, 64, 1'b0, 1'b0);

        frm[0] = 8'hA1; frm[1] = 8'hB2; frm[2] = 8'hC3; frm[3] = 8'hD4; frm[4] = 8'hE5;

        $display("[TB] short frame without FCS");
        base = cap_n;
        applyStimulus(5, -1, 0);
        checkFrame("short", base, 5, 1'b0, 1'b0);

        $display("[TB] receive error during byte 3");
        base = cap_n;
        applyStimulus(5, 3, 0);
        checkFrame("rxerr", base, 5, 1'b1, 1'b0);

        $display("[TB] truncated two dibits past boundary");
        base = cap_n;
        applyStimulus(5, -1, 2);
        checkFrame("trunc", base, 5, 1'b1, 1'b0);

        $display("[TB] carrier without SFD");
        base = cap_n;
        for (int i = 0; i < 10; i++) sendDibit(2'b01, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) sendDibit(2'b00, 1'b0, 1'b0);
        checkOutput("nosfd_count", cap_n - base, 0);

        base = cap_n;
        applyStimulus(5, -1, 0);
        checkFrame("after_nosfd", base, 5, 1'b0, 1'b0);

        checkOutput("vld_back_to_back", dbl_vld, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/eth_rmii_rx.md
# eth_rmii_rx

RMII receive front-end, module `eth`, sitting between an external 10/100 PHY and the packet-processing logic. It generates the PHY reference clock and reset, samples the 2-bit RMII receive bus, and strips preamble/SFD. It assembles LSB-first dibits into bytes and delivers them as a byte stream with end-of-frame, error and CRC-32 status. The transmit side is present at the pins but held idle.

## Interface
- No parameters.
- `clk` in 1: system clock, 100 MHz.
- `reset` in 1: asynchronous, active-high.
- `eth_clk` out 1: 50 MHz RMII reference clock to PHY, equal to `clk`/2.
- `eth_resetn` out 1: PHY reset, active-low.
- `eth_rxd` in 2: RMII receive dibit.
- `eth_crs_dv` in 1: RMII carrier sense / data valid.
- `eth_rx_err` in 1: PHY receive error.
- `eth_txd` out 2: transmit dibit, constant 0.
- `eth_tx_en` out 1: transmit enable, constant 0.
- `rx_data` out 8: received byte; first byte is destination MAC byte 0.
- `rx_vld` out 1: one-`clk` strobe, `rx_data` valid.
- `rx_last` out 1: qualifies `rx_vld`; final byte of frame (FCS byte 3).
- `rx_err` out 1: valid with `rx_last`; frame error.
- `rx_crc_ok` out 1: valid with `rx_last`; FCS correct.

## Operation
- Phase toggle `ph` flips every `clk` and drives `eth_clk`. RMII inputs are registered on the `clk` edge where `ph` goes 0→1, i.e. one sample per 20 ns.
- `eth_resetn` is a register loaded with `~reset`.
- State machine, advancing only on sample cycles:
  - IDLE: wait for `crs_dv`=1, then go to SYNC.
  - SYNC: leading 00 dibits are ignored. On dibit 11 with the previous dibit 01 (end of SFD 0xD5), go to DATA. If `crs_dv` is sampled 0, go to IDLE with no output.
  - DATA: shift register `sr <= {rxd, sr[7:2]}`. On every 4th dibit the completed byte moves into a one-byte hold register. If the hold register was already full, its old byte is first emitted with `rx_vld`=1, `rx_last`=0.
  - DATA, `crs_dv` sampled 0: emit the held byte with `rx_vld`=1, `rx_last`=1, `rx_err` and `rx_crc_ok`, then go to IDLE. If no byte is held, emit nothing.
- `rx_err` is set when either condition holds:
  - `eth_rx_err` was sampled 1 at any time in SYNC/DATA;
  - the frame ended with 1–3 dibits pending. Those partial bits are discarded.
- CRC:
  - reflected CRC-32, polynomial 0xEDB88320, initial value 0xFFFFFFFF;
  - updated 2 bits per DATA dibit over all bytes, FCS included;
  - `rx_crc_ok`=1 iff the register equals 0xDEBB20E3 at end of frame and the frame is byte-aligned.
- Preamble and SFD bytes are never output.

## Timing
- Reset values: all `rx_*` 0, `eth_clk` 0, `eth_resetn` 0, `eth_txd` 0, `eth_tx_en` 0, state IDLE, hold register empty, CRC 0xFFFFFFFF.
- Reset asserted mid-frame aborts the frame with no `rx_last`.
- `eth_resetn` rises on the first `clk` edge after `reset` drops.
- Byte N is output on the `clk` cycle after byte N+1 completes, which is 8 `clk` later.
- Last byte is output 1 `clk` after the sample cycle that sees `crs_dv`=0.
- `rx_vld` is never high on two consecutive cycles.
- `rx_data`, `rx_last`, `rx_err` and `rx_crc_ok` are don't-care when `rx_vld`=0; implementation drives them to 0.
- A new frame may begin on the sample right after IDLE is re-entered. CRC and error state reset on entering SYNC.

## Configuration
- `ETH_CRC_CHECK_EN` defined: CRC logic built, `rx_crc_ok` as above.
- Not defined: no CRC logic, `rx_crc_ok` constant 0. All else unchanged.

## Test plan
- In every scenario the bench holds each dibit for 2 `clk`, changes it mid-period relative to sampling, and precedes the preamble with 3 dibits of 00.
- Reset: while `reset`=1, all outputs are at their reset values; `eth_clk` toggles every `clk` after reset release; `eth_resetn`=1 one cycle later.
- Classic FCS example frame: 00 10 A4 7B … 0E 0F 10 11 followed by FCS E6 C5 3D B2, after 7×55 D5 → 64 bytes output in order, last = B2 with `rx_last`=1, `rx_crc_ok`=1, `rx_err`=0.
- Same frame with one payload byte corrupted (0x05→0x04) → same 64 bytes with the change, `rx_crc_ok`=0, `rx_err`=0.
- Payload A1 B2 C3 D4 E5 with no FCS → 5 bytes, `rx_last` on E5, `rx_crc_ok`=0.
- `eth_rx_err` pulsed during byte 3 → all bytes delivered, `rx_err`=1 at `rx_last`. Same frame truncated 2 dibits after a byte boundary → `rx_err`=1, partial byte dropped.
- `crs_dv` high for 10 dibits of 01 then low (no SFD) → no `rx_vld`. A following valid frame is then received correctly.
